// File: rtl/pipe_hazard_pkg.sv
// Shared encodings for the MIPS pipeline hazard controller:
// Tuse/Tnew constants and the forwarding-select values.
package pipe_hazard_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_D_GRF = 2'd0;
    localparam logic [1:0] FWD_D_E   = 2'd1;
    localparam logic [1:0] FWD_D_M   = 2'd2;
    localparam logic [1:0] FWD_D_W   = 2'd3;

    localparam logic [1:0] FWD_E_REG = 2'd0;
    localparam logic [1:0] FWD_E_M   = 2'd1;
    localparam logic [1:0] FWD_E_W   = 2'd2;

    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_md.sv
// Busy-window sequencer for the multi-cycle mult/div unit: busy from the cycle the
// op sits in E for exactly MULT_CYCLES or DIV_CYCLES cycles.
module md_busy_tracker
    import pipe_hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic e_md_start,
    input  logic e_md_div,
    output logic md_busy
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    logic [3:0] md_cnt;

    function automatic logic [3:0] sat_dec4(input logic [3:0] x);
        return (x == 4'd0) ? 4'd0 : x - 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt <= 4'd0;
        end else if (e_md_start) begin
            md_cnt <= e_md_div ? DIV_LOAD : MULT_LOAD;
        end else begin
            md_cnt <= sat_dec4(md_cnt);
        end
    end

    // The E-stage cycle itself is the first busy cycle; md_cnt covers the remainder.
    assign md_busy = e_md_start | (md_cnt != 4'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/forwarding controller for the 5-stage MIPS pipeline. Tracks E/M/W destination
// and Tnew, compares against the D-stage Tuse, and drives PC/F-D enables and D/E flush.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] d_rs_addr,
    input  logic [REG_AW-1:0] d_rt_addr,
    input  logic [1:0]        d_rs_tuse,
    input  logic [1:0]        d_rt_tuse,
    input  logic [REG_AW-1:0] d_wr_addr,
    input  logic [1:0]        d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_md_use,
    output logic              pc_en,
    output logic              fd_en,
    output logic              de_flush,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic              md_busy
);

    logic [REG_AW-1:0] rs_p0, rt_p0, wa_p0;
    logic [1:0]        tnew_p0;
    logic              md_start_p0, md_div_p0;
    logic [REG_AW-1:0] rt_p1, wa_p1;
    logic [1:0]        tnew_p1;
    logic [REG_AW-1:0] wa_p2;

    logic rs_stall, rt_stall, md_stall, stall;

    function automatic logic [1:0] sat_dec2(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // Returns {stall, fwd_select} for one D-stage source; only the nearest writer counts.
    function automatic logic [2:0] resolve_d(
        input logic [REG_AW-1:0] src,
        input logic [1:0]        tuse,
        input logic [REG_AW-1:0] wa_e,
        input logic [1:0]        tnew_e,
        input logic [REG_AW-1:0] wa_m,
        input logic [1:0]        tnew_m,
        input logic [REG_AW-1:0] wa_w
    );
        logic       st;
        logic [1:0] fw;
        st = 1'b0;
        fw = FWD_D_GRF;
        if (src != '0 && tuse != TUSE_NONE) begin
            if (src == wa_e) begin
                st = (tnew_e > tuse);
                fw = (tnew_e == TNEW_LINK) ? FWD_D_E : FWD_D_GRF;
            end else if (src == wa_m) begin
                st = (tnew_m > tuse);
                fw = (tnew_m == TNEW_LINK) ? FWD_D_M : FWD_D_GRF;
            end else if (src == wa_w) begin
                fw = FWD_D_W;
            end
        end
        return {st, fw};
    endfunction

    function automatic logic [1:0] resolve_e(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] wa_m,
        input logic [1:0]        tnew_m,
        input logic [REG_AW-1:0] wa_w
    );
        if (src != '0 && src == wa_m && tnew_m == TNEW_LINK) return FWD_E_M;
        if (src != '0 && src == wa_w) return FWD_E_W;
        return FWD_E_REG;
    endfunction

    // D -> E boundary: load the D fields, or a bubble while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_p0       <= '0;
            rt_p0       <= '0;
            wa_p0       <= '0;
            tnew_p0     <= 2'd0;
            md_start_p0 <= 1'b0;
            md_div_p0   <= 1'b0;
        end else if (stall) begin
            rs_p0       <= '0;
            rt_p0       <= '0;
            wa_p0       <= '0;
            tnew_p0     <= 2'd0;
            md_start_p0 <= 1'b0;
            md_div_p0   <= 1'b0;
        end else begin
            rs_p0       <= d_rs_addr;
            rt_p0       <= d_rt_addr;
            wa_p0       <= d_wr_addr;
            tnew_p0     <= d_tnew;
            md_start_p0 <= d_md_start;
            md_div_p0   <= d_md_div;
        end
    end

    // E -> M -> W boundaries: advance every cycle, Tnew counting down to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rt_p1   <= '0;
            wa_p1   <= '0;
            tnew_p1 <= 2'd0;
            wa_p2   <= '0;
        end else begin
            rt_p1   <= rt_p0;
            wa_p1   <= wa_p0;
            tnew_p1 <= sat_dec2(tnew_p0);
            wa_p2   <= wa_p1;
        end
    end

    md_busy_tracker #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md (
        .clk       (clk),
        .rst       (rst),
        .e_md_start(md_start_p0),
        .e_md_div  (md_div_p0),
        .md_busy   (md_busy)
    );

    assign {rs_stall, fwd_rs_d} = resolve_d(d_rs_addr, d_rs_tuse, wa_p0, tnew_p0,
                                            wa_p1, tnew_p1, wa_p2);
    assign {rt_stall, fwd_rt_d} = resolve_d(d_rt_addr, d_rt_tuse, wa_p0, tnew_p0,
                                            wa_p1, tnew_p1, wa_p2);

    assign md_stall = (d_md_use | d_md_start) & md_busy;
    assign stall    = rs_stall | rt_stall | md_stall;
    assign pc_en    = ~stall;
    assign fd_en    = ~stall;
    assign de_flush = stall;

    assign fwd_rs_e = resolve_e(rs_p0, wa_p1, tnew_p1, wa_p2);
    assign fwd_rt_e = resolve_e(rt_p0, wa_p1, tnew_p1, wa_p2);
    assign fwd_rt_m = (rt_p1 != '0) && (rt_p1 == wa_p2);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by random instruction
// streams, all checked against an instruction-history reference model.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wa;
        logic [1:0] tnew;
        logic       md;
        logic       div;
    } ins_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] d_rs_addr, d_rt_addr, d_wr_addr;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       pc_en, fd_en, de_flush, fwd_rt_m, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    int checks = 0;
    int failures = 0;

    // hist[c] is the instruction occupying E during model cycle c
    ins_t hist [0:4095];
    int   cyc;
    int   rst_cyc;
    logic last_stall;

    logic       exp_stall, exp_busy, exp_fwd_rt_m;
    logic [1:0] exp_fwd_rs_d, exp_fwd_rt_d, exp_fwd_rs_e, exp_fwd_rt_e;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .d_rs_addr (d_rs_addr),
        .d_rt_addr (d_rt_addr),
        .d_rs_tuse (d_rs_tuse),
        .d_rt_tuse (d_rt_tuse),
        .d_wr_addr (d_wr_addr),
        .d_tnew    (d_tnew),
        .d_md_start(d_md_start),
        .d_md_div  (d_md_div),
        .d_md_use  (d_md_use),
        .pc_en     (pc_en),
        .fd_en     (fd_en),
        .de_flush  (de_flush),
        .fwd_rs_d  (fwd_rs_d),
        .fwd_rt_d  (fwd_rt_d),
        .fwd_rs_e  (fwd_rs_e),
        .fwd_rt_e  (fwd_rt_e),
        .fwd_rt_m  (fwd_rt_m),
        .md_busy   (md_busy)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Instruction k stages past E; its Tnew has counted down by k.
    function automatic ins_t stage_at(int k);
        ins_t r;
        int   idx;
        idx = cyc - k;
        if (idx < rst_cyc || idx < 0) begin
            r = '0;
        end else begin
            r = hist[idx];
            r.tnew = (int'(r.tnew) > k) ? 2'(int'(r.tnew) - k) : 2'd0;
        end
        return r;
    endfunction

    task automatic dep(input logic [4:0] s, input logic [1:0] tu,
                       output logic st, output logic [1:0] fw);
        ins_t r;
        st = 1'b0;
        fw = 2'd0;
        if (s != 5'd0 && tu != 2'd3) begin
            for (int k = 0; k < 3; k++) begin
                r = stage_at(k);
                if (r.wa == s) begin
                    if (k < 2 && r.tnew > tu) st = 1'b1;
                    fw = (r.tnew == 2'd0) ? 2'(k + 1) : 2'd0;
                    break;
                end
            end
        end
    endtask

    // Busy while fewer than N cycles have elapsed since the latest mult/div sat in E.
    function automatic logic model_busy();
        for (int s = cyc; s >= rst_cyc && s >= 0 && s > cyc - 10; s--) begin
            if (hist[s].md) return (cyc - s) < (hist[s].div ? 10 : 5);
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] e_sel(input logic [4:0] s, input ins_t m, input ins_t w);
        if (s != 5'd0 && s == m.wa && m.tnew == 2'd0) return 2'd1;
        if (s != 5'd0 && s == w.wa) return 2'd2;
        return 2'd0;
    endfunction

    task automatic eval_model();
        logic st_rs, st_rt;
        ins_t e, m, w;
        e = stage_at(0);
        m = stage_at(1);
        w = stage_at(2);
        dep(d_rs_addr, d_rs_tuse, st_rs, exp_fwd_rs_d);
        dep(d_rt_addr, d_rt_tuse, st_rt, exp_fwd_rt_d);
        exp_busy     = model_busy();
        exp_stall    = st_rs | st_rt | ((d_md_use | d_md_start) & exp_busy);
        exp_fwd_rs_e = e_sel(e.rs, m, w);
        exp_fwd_rt_e = e_sel(e.rt, m, w);
        exp_fwd_rt_m = (m.rt != 5'd0) && (m.rt == w.wa);
    endtask

    task automatic setd(input logic [4:0] rs, input logic [1:0] rsu,
                        input logic [4:0] rt, input logic [1:0] rtu,
                        input logic [4:0] wa, input logic [1:0] tn,
                        input logic ms, input logic mdv, input logic mu);
        d_rs_addr = rs; d_rs_tuse = rsu; d_rt_addr = rt; d_rt_tuse = rtu;
        d_wr_addr = wa; d_tnew = tn; d_md_start = ms; d_md_div = mdv; d_md_use = mu;
    endtask

    task automatic nop();
        setd(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Check one cycle against the model, then clock and record what enters E.
    task automatic tick();
        #2;
        eval_model();
        chk("pc_en", {3'b0, pc_en}, {3'b0, ~exp_stall});
        chk("fd_en", {3'b0, fd_en}, {3'b0, ~exp_stall});
        chk("de_flush", {3'b0, de_flush}, {3'b0, exp_stall});
        chk("fwd_rs_d", {2'b0, fwd_rs_d}, {2'b0, exp_fwd_rs_d});
        chk("fwd_rt_d", {2'b0, fwd_rt_d}, {2'b0, exp_fwd_rt_d});
        chk("fwd_rs_e", {2'b0, fwd_rs_e}, {2'b0, exp_fwd_rs_e});
        chk("fwd_rt_e", {2'b0, fwd_rt_e}, {2'b0, exp_fwd_rt_e});
        chk("fwd_rt_m", {3'b0, fwd_rt_m}, {3'b0, exp_fwd_rt_m});
        chk("md_busy", {3'b0, md_busy}, {3'b0, exp_busy});
        last_stall = exp_stall;
        @(posedge clk);
        if (rst) begin
            rst_cyc = cyc + 1;
            hist[cyc + 1] = '0;
        end else if (exp_stall) begin
            hist[cyc + 1] = '0;
        end else begin
            hist[cyc + 1] = '{rs: d_rs_addr, rt: d_rt_addr, wa: d_wr_addr,
                              tnew: d_tnew, md: d_md_start, div: d_md_div};
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        rst_cyc = 1;
        last_stall = 1'b0;
        for (int i = 0; i < 4096; i++) hist[i] = '0;

        // Post-reset output state
        #2;
        chk("rst_pc_en", {3'b0, pc_en}, 4'd1);
        chk("rst_fd_en", {3'b0, fd_en}, 4'd1);
        chk("rst_de_flush", {3'b0, de_flush}, 4'd0);
        chk("rst_fwd", {fwd_rs_d, fwd_rt_d}, 4'd0);
        chk("rst_fwd_e", {fwd_rs_e, fwd_rt_e}, 4'd0);
        chk("rst_fwd_m_busy", {2'b0, fwd_rt_m, md_busy}, 4'd0);
        tick();

        // Load-use: lw $1 then addu reading $1 at Tuse 1
        setd(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        setd(5'd1, 2'd1, 5'd2, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        #2;
        chk("t1_stall_pc_en", {3'b0, pc_en}, 4'd0);
        chk("t1_stall_flush", {3'b0, de_flush}, 4'd1);
        tick();
        #2;
        chk("t1_release", {3'b0, pc_en}, 4'd1);
        tick();
        nop();
        #2;
        chk("t1_fwd_rs_e", {2'b0, fwd_rs_e}, 4'd2);
        tick();
        drain();

        // ALU result needed by a branch at Tuse 0
        setd(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        setd(5'd3, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("t2_stall", {3'b0, de_flush}, 4'd1);
        tick();
        #2;
        chk("t2_fwd_rs_d", {2'b0, fwd_rs_d}, 4'd2);
        chk("t2_no_stall", {3'b0, pc_en}, 4'd1);
        tick();
        drain();

        // mult then mfhi: 5-cycle busy window; then div: 10
        for (int n = 0; n < 2; n++) begin
            setd(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, n[0], 1'b0);
            tick();
            setd(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < (n == 0 ? 5 : 10); i++) begin
                #2;
                chk("t3_busy", {3'b0, md_busy}, 4'd1);
                chk("t3_mfhi_stall", {3'b0, de_flush}, 4'd1);
                tick();
            end
            #2;
            chk("t3_busy_end", {3'b0, md_busy}, 4'd0);
            chk("t3_mfhi_go", {3'b0, pc_en}, 4'd1);
            tick();
            drain();
        end

        // Writes to $0 are never a hazard
        setd(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        setd(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("t4_no_stall", {3'b0, pc_en}, 4'd1);
        chk("t4_fwd", {2'b0, fwd_rs_d}, 4'd0);
        tick();
        drain();

        // E and M both write $5: the E copy wins
        for (int n = 0; n < 2; n++) begin
            setd(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, (n == 0) ? 2'd2 : 2'd0, 1'b0, 1'b0, 1'b0);
            tick();
            setd(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, (n == 0) ? 2'd0 : 2'd1, 1'b0, 1'b0, 1'b0);
            tick();
            setd(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            #2;
            chk("t5_fwd_rs_d", {2'b0, fwd_rs_d}, (n == 0) ? 4'd1 : 4'd0);
            chk("t5_stall", {3'b0, de_flush}, (n == 0) ? 4'd0 : 4'd1);
            tick();
            drain();
        end

        // Reset in the middle of a div
        setd(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        nop();
        repeat (4) tick();
        setd(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #2;
        chk("t6_busy_before", {3'b0, md_busy}, 4'd1);
        tick();
        rst = 1'b0;
        #2;
        chk("t6_busy_cleared", {3'b0, md_busy}, 4'd0);
        chk("t6_pc_en", {3'b0, pc_en}, 4'd1);
        chk("t6_fwd", {fwd_rs_e, fwd_rt_e}, 4'd0);
        tick();
        drain();

        // Random instruction stream over a small register set; stalled D holds
        for (int i = 0; i < 1500; i++) begin
            if (!last_stall) begin
                setd(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                     ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0));
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
